// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: preamble of ones, W data bits, one stop zero.
// All line-facing outputs are registered so the serial line never glitches.
module serial_frame_tx #(
  parameter int W         = 8,
  parameter int PRE_LEN   = 3,
  parameter int LSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out,
  output logic         busy,
  output logic         done
);

  localparam int MAXL = (PRE_LEN > W) ? PRE_LEN : W;
  localparam int CW   = $clog2(MAXL) + 1;
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_STOP
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_shift;
  logic           r_out;
  logic           r_busy;
  logic           r_done;
  logic           w_bit;
  logic [W-1:0]   w_shift_nxt;

  assign w_bit       = (LSB_FIRST != 0) ? r_shift[0] : r_shift[W-1];
  assign w_shift_nxt = (LSB_FIRST != 0) ? (r_shift >> 1) : (r_shift << 1);

  assign in_ready = (r_state == S_IDLE) && !rst;
  assign out      = r_out;
  assign busy     = r_busy;
  assign done     = r_done;

  // r_out/r_busy/r_done are loaded with the values belonging to the state
  // being entered, so they line up with r_state in every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_state <= S_PRE;
            r_cnt   <= '0;
            r_shift <= in_data;
            r_out   <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_out  <= 1'b0;
            r_busy <= 1'b0;
          end
        end
        S_PRE: begin
          r_busy <= 1'b1;
          if (r_cnt == PRE_LAST) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
            r_out   <= w_bit;
            r_shift <= w_shift_nxt;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_out <= 1'b1;
          end
        end
        S_DATA: begin
          r_busy <= 1'b1;
          if (r_cnt == DATA_LAST) begin
            r_state <= S_STOP;
            r_cnt   <= '0;
            r_out   <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_out   <= w_bit;
            r_shift <= w_shift_nxt;
          end
        end
        S_STOP: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_out   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_out   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
